// File: rtl/const_load_pkg.sv
/**********************************************************************
 * Module      : const_load_pkg
 * Description : Shared types and constants for the LI -> LUI/ORI
 *               micro-op sequencer.
 * Revision    : 1.0 - initial release
 **********************************************************************/
`default_nettype none

package const_load_pkg;

    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LUI  = 2'b01,
        OP_ORI  = 2'b10
    } uop_op_t;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_HI   = 2'd1;
    localparam state_t c_ST_LO   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/const_load_sequencer.sv
/**********************************************************************
 * Module      : const_load_sequencer
 * Description : Splits a constant into LUI (upper half) + ORI (lower
 *               half) micro-ops, skipping whichever half is redundant.
 * Revision    : 1.0 - initial release
 **********************************************************************/
`default_nettype none

module const_load_sequencer
    import const_load_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int HALF_W   = const_load_pkg::HALF_W,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_const,
    input  logic [REG_W-1:0]  req_rd,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [1:0]        uop_op,
    output logic [REG_W-1:0]  uop_rd,
    output logic [REG_W-1:0]  uop_rs,
    output logic [DATA_W-1:0] uop_imm,
    output logic              uop_last,
    output logic [CNT_W-1:0]  uop_count
);

    localparam logic [REG_W-1:0]  c_ZERO_REG = REG_W'(ZERO_REG);
    localparam logic [HALF_W-1:0] c_HALF_0   = '0;

    state_t             r_state;
    logic               r_valid;
    uop_op_t            r_op;
    logic [REG_W-1:0]   r_rd;
    logic [REG_W-1:0]   r_rs;
    logic [DATA_W-1:0]  r_imm;
    logic               r_last;
    logic [HALF_W-1:0]  r_lo;
    logic [CNT_W-1:0]   r_count;

    logic [HALF_W-1:0]  w_hi;
    logic [HALF_W-1:0]  w_lo;
    logic               w_handoff;

    assign w_hi      = req_const[DATA_W-1:HALF_W];
    assign w_lo      = req_const[HALF_W-1:0];
    assign w_handoff = r_valid & uop_ready;

    // Acceptance depends on state alone so the request side never sees uop_ready.
    assign req_ready = (r_state == c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_valid <= 1'b0;
            r_op    <= OP_NONE;
            r_rd    <= '0;
            r_rs    <= '0;
            r_imm   <= '0;
            r_last  <= 1'b0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_valid <= 1'b1;
                        r_rd    <= req_rd;
                        r_lo    <= w_lo;
                        r_rs    <= c_ZERO_REG;
                        if (w_hi != c_HALF_0) begin
                            r_state <= c_ST_HI;
                            r_op    <= OP_LUI;
                            r_imm   <= {w_hi, c_HALF_0};
                            r_last  <= (w_lo == c_HALF_0);
                        end else begin
                            // Upper half zero: a single ORI from the zero register suffices.
                            r_state <= c_ST_LO;
                            r_op    <= OP_ORI;
                            r_imm   <= {c_HALF_0, w_lo};
                            r_last  <= 1'b1;
                        end
                    end
                end
                c_ST_HI: begin
                    if (uop_ready) begin
                        if (r_lo != c_HALF_0) begin
                            r_state <= c_ST_LO;
                            r_op    <= OP_ORI;
                            r_rs    <= r_rd;
                            r_imm   <= {c_HALF_0, r_lo};
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_valid <= 1'b0;
                            r_op    <= OP_NONE;
                            r_rs    <= '0;
                            r_imm   <= '0;
                            r_last  <= 1'b0;
                        end
                    end
                end
                c_ST_LO: begin
                    if (uop_ready) begin
                        r_state <= c_ST_IDLE;
                        r_valid <= 1'b0;
                        r_op    <= OP_NONE;
                        r_rs    <= '0;
                        r_imm   <= '0;
                        r_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                    r_op    <= OP_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_handoff) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign uop_valid = r_valid;
    assign uop_op    = r_op;
    assign uop_rd    = r_rd;
    assign uop_rs    = r_rs;
    assign uop_imm   = r_imm;
    assign uop_last  = r_last;
    assign uop_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_const_load_sequencer.sv
/**********************************************************************
 * Module      : tb_const_load_sequencer
 * Description : Directed vector bench for const_load_sequencer
 *               (4-bit counter build so the wrap is reachable).
 * Revision    : 1.0 - initial release
 **********************************************************************/
`default_nettype none

module tb_const_load_sequencer;

    localparam int c_CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_const;
    logic [4:0]        req_rd;
    logic              uop_valid;
    logic              uop_ready;
    logic [1:0]        uop_op;
    logic [4:0]        uop_rd;
    logic [4:0]        uop_rs;
    logic [31:0]       uop_imm;
    logic              uop_last;
    logic [c_CNT_W-1:0] uop_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [c_CNT_W-1:0] exp_count = '0;

    const_load_sequencer #(
        .DATA_W  (32),
        .HALF_W  (16),
        .REG_W   (5),
        .ZERO_REG(0),
        .CNT_W   (c_CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_const(req_const),
        .req_rd   (req_rd),
        .uop_valid(uop_valid),
        .uop_ready(uop_ready),
        .uop_op   (uop_op),
        .uop_rd   (uop_rd),
        .uop_rs   (uop_rs),
        .uop_imm  (uop_imm),
        .uop_last (uop_last),
        .uop_count(uop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cval;
        logic [4:0]  rd;
        int          nuops;
        logic [1:0]  op0;  logic [4:0] rs0; logic [31:0] imm0; logic last0;
        logic [1:0]  op1;  logic [4:0] rs1; logic [31:0] imm1; logic last1;
    } vec_t;

    vec_t vecs [7];
    vec_t v_big;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_uop(input string tag, input logic [1:0] op, input logic [4:0] rd,
                           input logic [4:0] rs, input logic [31:0] imm, input logic last);
        chk({tag, "_valid"}, 32'(uop_valid), 32'd1);
        chk({tag, "_op"},    32'(uop_op),    32'(op));
        chk({tag, "_rd"},    32'(uop_rd),    32'(rd));
        chk({tag, "_rs"},    32'(uop_rs),    32'(rs));
        chk({tag, "_imm"},   uop_imm,        imm);
        chk({tag, "_last"},  32'(uop_last),  32'(last));
        chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
    endtask

    // Issue one constant with uop_ready held high and check every micro-op.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_const = v.cval;
        req_rd    = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        chk_uop("uop0", v.op0, v.rd, v.rs0, v.imm0, v.last0);
        exp_count = exp_count + 1'b1;
        if (v.nuops == 2) begin
            @(negedge clk);
            chk_uop("uop1", v.op1, v.rd, v.rs1, v.imm1, v.last1);
            exp_count = exp_count + 1'b1;
        end
        @(negedge clk);
        chk("done_valid", 32'(uop_valid), 32'd0);
        chk("done_req_ready", 32'(req_ready), 32'd1);
        chk("done_count", 32'(uop_count), 32'(exp_count));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h12345678, 5'd3,  2, 2'b01, 5'd0, 32'h12340000, 1'b0, 2'b10, 5'd3,  32'h00005678, 1'b1};
        vecs[1] = '{32'hABCD0000, 5'd7,  1, 2'b01, 5'd0, 32'hABCD0000, 1'b1, 2'b00, 5'd0,  32'h0,        1'b0};
        vecs[2] = '{32'h0000BEEF, 5'd4,  1, 2'b10, 5'd0, 32'h0000BEEF, 1'b1, 2'b00, 5'd0,  32'h0,        1'b0};
        vecs[3] = '{32'h00000000, 5'd4,  1, 2'b10, 5'd0, 32'h00000000, 1'b1, 2'b00, 5'd0,  32'h0,        1'b0};
        vecs[4] = '{32'hFFFFFFFF, 5'd31, 2, 2'b01, 5'd0, 32'hFFFF0000, 1'b0, 2'b10, 5'd31, 32'h0000FFFF, 1'b1};
        vecs[5] = '{32'h00010001, 5'd0,  2, 2'b01, 5'd0, 32'h00010000, 1'b0, 2'b10, 5'd0,  32'h00000001, 1'b1};
        vecs[6] = '{32'h80000000, 5'd1,  1, 2'b01, 5'd0, 32'h80000000, 1'b1, 2'b00, 5'd0,  32'h0,        1'b0};
        v_big = vecs[0];

        rst = 1'b1; req_valid = 1'b0; req_const = '0; req_rd = '0; uop_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid",     32'(uop_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_op",        32'(uop_op),    32'd0);
        chk("rst_rd",        32'(uop_rd),    32'd0);
        chk("rst_rs",        32'(uop_rs),    32'd0);
        chk("rst_imm",       uop_imm,        32'd0);
        chk("rst_last",      32'(uop_last),  32'd0);
        chk("rst_count",     32'(uop_count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Back-pressure on the LUI, with a competing request that must be ignored.
        @(negedge clk);
        uop_ready = 1'b0;
        req_valid = 1'b1; req_const = 32'h12345678; req_rd = 5'd3;
        @(negedge clk);
        req_const = 32'hDEADBEEF; req_rd = 5'd9;
        for (int k = 0; k < 3; k++) begin
            chk_uop("stall_lui", 2'b01, 5'd3, 5'd0, 32'h12340000, 1'b0);
            chk("stall_count", 32'(uop_count), 32'(exp_count));
            @(negedge clk);
        end
        req_valid = 1'b0;
        uop_ready = 1'b1;
        chk_uop("stall_lui_release", 2'b01, 5'd3, 5'd0, 32'h12340000, 1'b0);
        exp_count = exp_count + 1'b1;
        @(negedge clk);
        chk_uop("stall_ori", 2'b10, 5'd3, 5'd3, 32'h00005678, 1'b1);
        exp_count = exp_count + 1'b1;
        @(negedge clk);
        chk("stall_done_valid", 32'(uop_valid), 32'd0);
        chk("stall_done_count", 32'(uop_count), 32'(exp_count));
        @(negedge clk);
        chk("stall_no_extra", 32'(uop_valid), 32'd0);

        // Reset while the ORI is pending.
        req_valid = 1'b1; req_const = 32'h12345678; req_rd = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk_uop("pre_rst_ori", 2'b10, 5'd3, 5'd3, 32'h00005678, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = '0;
        chk("midrst_valid",     32'(uop_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_count",     32'(uop_count), 32'd0);
        run_vec(v_big);

        // 16 handoffs from a fresh reset wrap the 4-bit counter to zero.
        do_reset();
        for (int k = 0; k < 8; k++) run_vec(v_big);
        chk("wrap_count_zero", 32'(uop_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
